// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the six-digit multiplexed display scanner.
// Holds the seven-segment patterns ({g,f,e,d,c,b,a}, active-high), the digit
// index assignments and the idle value of the active-low digit enables.
package disp_pkg;

    typedef logic [2:0] digit_idx_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] Seg0     = 7'b0111111;
    localparam logic [6:0] Seg1     = 7'b0000110;
    localparam logic [6:0] Seg2     = 7'b1011011;
    localparam logic [6:0] Seg3     = 7'b1001111;
    localparam logic [6:0] Seg4     = 7'b1100110;
    localparam logic [6:0] Seg5     = 7'b1101101;
    localparam logic [6:0] Seg6     = 7'b1111101;
    localparam logic [6:0] Seg7     = 7'b0000111;
    localparam logic [6:0] Seg8     = 7'b1111111;
    localparam logic [6:0] Seg9     = 7'b1101111;
    localparam logic [6:0] SegDash  = 7'b1000000;
    localparam logic [6:0] SegBlank = 7'b0000000;

    // Scan order: seconds low digit first, hours high digit last
    localparam digit_idx_t IdxSecL  = 3'd0;
    localparam digit_idx_t IdxSecH  = 3'd1;
    localparam digit_idx_t IdxMinL  = 3'd2;
    localparam digit_idx_t IdxMinH  = 3'd3;
    localparam digit_idx_t IdxHourL = 3'd4;
    localparam digit_idx_t IdxHourH = 3'd5;

    // All digit enables off (active-low)
    localparam logic [5:0] AnReset = 6'b111111;

endpackage

// File: rtl/bcd2seg.sv
// bcd2seg: combinational BCD to seven-segment decoder.
// Ports:
//   i_bcd  - 4-bit BCD digit
//   o_seg  - active-high segments {g,f,e,d,c,b,a}; values 10-15 show a dash
module bcd2seg
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SegDash;
        case (i_bcd)
            4'd0:    o_seg = Seg0;
            4'd1:    o_seg = Seg1;
            4'd2:    o_seg = Seg2;
            4'd3:    o_seg = Seg3;
            4'd4:    o_seg = Seg4;
            4'd5:    o_seg = Seg5;
            4'd6:    o_seg = Seg6;
            4'd7:    o_seg = Seg7;
            4'd8:    o_seg = Seg8;
            4'd9:    o_seg = Seg9;
            default: o_seg = SegDash;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// disp_scan: six-digit multiplexed seven-segment scanner with per-pair blink.
// A prescaler holds each digit for DIV cycles; the digit index walks 0..5.
// All six BCD inputs are captured together at each 5->0 wrap so a frame never
// mixes old and new digits.
// Ports:
//   CP             - clock, rising edge
//   CR             - synchronous active-high clear, overrides everything
//   EN             - 1 = scan, 0 = blank display and hold all scan state
//   HourH..SecL    - BCD digits from the time counters
//   Blink          - blink mask {hours, minutes, seconds}
//   Seg            - registered active-high segments {g,f,e,d,c,b,a}
//   AN             - registered active-low digit enables, AN[0]=SecL .. AN[5]=HourH
//   Frame          - one-cycle pulse, high in the first cycle the new snapshot is held
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic [3:0] HourH,
    input  logic [3:0] HourL,
    input  logic [3:0] MinH,
    input  logic [3:0] MinL,
    input  logic [3:0] SecH,
    input  logic [3:0] SecL,
    input  logic [2:0] Blink,
    output logic [6:0] Seg,
    output logic [5:0] AN,
    output logic       Frame
);

    localparam int unsigned PrescW = $clog2(DIV);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);

    logic [PrescW-1:0] r_presc;
    digit_idx_t        r_idx;
    logic [3:0]        r_snap [6];
    logic [BlinkW-1:0] r_blink_cnt;
    logic              r_blink_phase;
    logic [6:0]        r_seg;
    logic [5:0]        r_an;
    logic              r_frame;

    logic              w_presc_wrap;
    logic              w_frame_wrap;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg;
    logic [5:0]        w_an_sel;
    logic              w_pair_blink;

    // Both wraps are qualified by EN so nothing advances while scanning is held
    assign w_presc_wrap = EN && (r_presc == PrescMax);
    assign w_frame_wrap = w_presc_wrap && (r_idx == IdxHourH);

    // Snapshot mux, digit enable and blink-pair select for the current index
    always_comb begin
        w_digit      = 4'h0;
        w_an_sel     = AnReset;
        w_pair_blink = 1'b0;
        case (r_idx)
            IdxSecL:  begin w_digit = r_snap[0]; w_an_sel = 6'b111110; w_pair_blink = Blink[0]; end
            IdxSecH:  begin w_digit = r_snap[1]; w_an_sel = 6'b111101; w_pair_blink = Blink[0]; end
            IdxMinL:  begin w_digit = r_snap[2]; w_an_sel = 6'b111011; w_pair_blink = Blink[1]; end
            IdxMinH:  begin w_digit = r_snap[3]; w_an_sel = 6'b110111; w_pair_blink = Blink[1]; end
            IdxHourL: begin w_digit = r_snap[4]; w_an_sel = 6'b101111; w_pair_blink = Blink[2]; end
            IdxHourH: begin w_digit = r_snap[5]; w_an_sel = 6'b011111; w_pair_blink = Blink[2]; end
            default:  begin w_digit = 4'h0;      w_an_sel = AnReset;   w_pair_blink = 1'b0;     end
        endcase
    end

    bcd2seg u_bcd2seg (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge CP) begin
        if (CR) begin
            r_presc       <= '0;
            r_idx         <= IdxSecL;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= 4'h0;
            end
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_seg         <= SegBlank;
            r_an          <= AnReset;
            r_frame       <= 1'b0;
        end else if (EN) begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;

            if (w_presc_wrap) begin
                r_idx <= (r_idx == IdxHourH) ? IdxSecL : r_idx + 3'd1;
            end

            if (w_frame_wrap) begin
                r_snap[0] <= SecL;
                r_snap[1] <= SecH;
                r_snap[2] <= MinL;
                r_snap[3] <= MinH;
                r_snap[4] <= HourL;
                r_snap[5] <= HourH;
                if (r_blink_cnt == BlinkMax) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            // Outputs follow the index one cycle late; blinking only gates AN
            r_an    <= (r_blink_phase && w_pair_blink) ? AnReset : w_an_sel;
            r_seg   <= w_seg;
            r_frame <= w_frame_wrap;
        end else begin
            r_an    <= AnReset;
            r_seg   <= SegBlank;
            r_frame <= 1'b0;
        end
    end

    assign Seg   = r_seg;
    assign AN    = r_an;
    assign Frame = r_frame;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: self-checking bench for disp_scan with DIV=4, BLINK_FRAMES=2.
// A reference model, evaluated just before each clock edge, pushes the
// expected {AN, Seg, Frame} for that edge; each test pops and compares.
module tb_disp_scan;

    localparam int unsigned TbDiv    = 4;
    localparam int unsigned TbBf     = 2;
    localparam int          FrameLen = TbDiv * 6;

    logic       CP;
    logic       CR;
    logic       EN;
    logic [2:0] Blink;
    logic [3:0] dig [6];
    logic [3:0] HourH, HourL, MinH, MinL, SecH, SecL;
    logic [6:0] Seg;
    logic [5:0] AN;
    logic       Frame;

    assign SecL  = dig[0];
    assign SecH  = dig[1];
    assign MinL  = dig[2];
    assign MinH  = dig[3];
    assign HourL = dig[4];
    assign HourH = dig[5];

    disp_scan #(
        .DIV          (TbDiv),
        .BLINK_FRAMES (TbBf)
    ) dut (
        .CP    (CP),
        .CR    (CR),
        .EN    (EN),
        .HourH (HourH),
        .HourL (HourL),
        .MinH  (MinH),
        .MinL  (MinL),
        .SecH  (SecH),
        .SecL  (SecL),
        .Blink (Blink),
        .Seg   (Seg),
        .AN    (AN),
        .Frame (Frame)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         m_n   = 0;   // enabled edges since last clear
    logic [3:0] m_snap [6];

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected outputs after the coming edge, from the inputs now applied
    task automatic model_edge();
        exp_t e;
        int   idx;
        int   ph;
        if (CR) begin
            e = '{an: 6'h3F, seg: 7'h00, frame: 1'b0};
            m_n = 0;
            for (int i = 0; i < 6; i++) m_snap[i] = 4'h0;
        end else if (!EN) begin
            e = '{an: 6'h3F, seg: 7'h00, frame: 1'b0};
        end else begin
            idx   = (m_n / TbDiv) % 6;
            ph    = (m_n / (FrameLen * TbBf)) % 2;
            e.an  = 6'h3F;
            if (!(ph == 1 && Blink[idx / 2])) e.an[idx] = 1'b0;
            e.seg = seg_of(m_snap[idx]);
            m_n++;
            e.frame = (m_n % FrameLen == 0);
            if (e.frame) begin
                for (int i = 0; i < 6; i++) m_snap[i] = dig[i];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 6; i++) dig[i] = 4'd8;
        Blink = 3'b000;
        EN    = 1'b1;
        CR    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL reset sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
            n_cmp++;
            if (AN !== 6'b111111 || Seg !== 7'b0000000 || Frame !== 1'b0) begin
                n_err++;
                $display("FAIL reset_const c%0d: AN=%b Seg=%b Frame=%b want 111111 0000000 0",
                         c, AN, Seg, Frame);
            end
        end
        CR = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e;
        bit   seen = 0;
        dig[5] = 4'd2; dig[4] = 4'd3; dig[3] = 4'd5;
        dig[2] = 4'd9; dig[1] = 4'd4; dig[0] = 4'd7;
        for (int c = 0; c < 2 * FrameLen + 8; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL scan sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
            if (seen && AN === 6'b011111) begin
                n_cmp++;
                if (Seg !== 7'b1011011) begin
                    n_err++;
                    $display("FAIL scan_hourh c%0d: Seg=%b want 1011011", c, Seg);
                end
            end
            if (Frame === 1'b1) seen = 1;
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   gap = 0;
        bit   prev = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL wrap_pre sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
        end
        dig[0] = 4'd1;
        for (int c = 0; c < 3 * FrameLen; c++) begin
            step();
            gap++;
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL wrap sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
            if (Frame === 1'b1) begin
                if (prev) begin
                    n_cmp++;
                    if (gap != FrameLen) begin
                        n_err++;
                        $display("FAIL wrap_period: gap=%0d want %0d", gap, FrameLen);
                    end
                end
                prev = 1;
                gap  = 0;
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int   hidden = 0;
        Blink = 3'b100;
        for (int c = 0; c < 5 * FrameLen; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL blink sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
            if (AN === 6'b111111) hidden++;
        end
        // Two of the five frames land in a blank window: 8 hidden hour cycles each
        n_cmp++;
        if (hidden < 2 * 2 * TbDiv) begin
            n_err++;
            $display("FAIL blink_hidden: blanked cycles=%0d want >= %0d", hidden, 4 * TbDiv);
        end
        Blink = 3'b000;
    endtask

    task automatic test_invalid();
        exp_t e;
        bit   seen = 0;
        dig[0] = 4'hC;
        for (int c = 0; c < 2 * FrameLen + 4; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL invalid sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
            if (seen && AN === 6'b111110) begin
                n_cmp++;
                if (Seg !== 7'b1000000) begin
                    n_err++;
                    $display("FAIL invalid_dash c%0d: Seg=%b want 1000000", c, Seg);
                end
            end
            if (Frame === 1'b1) seen = 1;
        end
    endtask

    task automatic test_en_pause();
        exp_t e;
        for (int c = 0; c < 2 * TbDiv && (m_n % TbDiv) != 2; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL pause_pre sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
        end
        EN = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (AN !== 6'b111111 || Seg !== 7'b0000000 || Frame !== 1'b0) begin
                n_err++;
                $display("FAIL pause_blank c%0d: AN=%b Seg=%b Frame=%b want 111111 0000000 0",
                         c, AN, Seg, Frame);
            end
        end
        EN = 1'b1;
        for (int c = 0; c < FrameLen + 4; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL pause_resume sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
        end
    endtask

    task automatic test_cr_mid();
        exp_t e;
        for (int c = 0; c < 7; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL crmid_pre sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
        end
        CR = 1'b1;
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (AN !== 6'b111111 || Seg !== 7'b0000000 || Frame !== 1'b0) begin
            n_err++;
            $display("FAIL crmid_const: AN=%b Seg=%b Frame=%b want 111111 0000000 0",
                     AN, Seg, Frame);
        end
        CR = 1'b0;
        // Snapshots were cleared, so the first frame after clear shows zeros
        for (int c = 0; c < FrameLen + 6; c++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({AN, Seg, Frame} !== e) begin
                n_err++;
                $display("FAIL crmid sb c%0d: AN=%b Seg=%b Frame=%b want %b %b %b",
                         c, AN, Seg, Frame, e.an, e.seg, e.frame);
            end
        end
    endtask

    initial begin
        CR    = 1'b1;
        EN    = 1'b1;
        Blink = 3'b000;
        for (int i = 0; i < 6; i++) begin
            dig[i]    = 4'h0;
            m_snap[i] = 4'h0;
        end
        test_reset();
        test_scan();
        test_wrap();
        test_blink();
        test_invalid();
        test_en_pause();
        test_cr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
